// File: rtl/burst_ram_initiator_pkg.sv
// Shared FSM state encodings and burst RAM command codes.
package burst_ram_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WRITE_BEATS  = 2'd1,
    ST_READ_COLLECT = 2'd2,
    ST_DRAIN        = 2'd3
  } state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // A single-beat burst still needs a one-bit counter.
  function automatic int beat_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/burst_ram_initiator_if.sv
// Line request/response channel plus burst RAM command bus; master is the initiator, slave is client + RAM.
interface burst_ram_initiator_if #(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int DATA_BITWIDTH  = 64,
  parameter int BURST_COUNT    = 4
);
  logic                                   req_valid;
  logic                                   req_write;
  logic [DEPTH_BITWIDTH-1:0]              req_addr;
  logic [DATA_BITWIDTH*BURST_COUNT-1:0]   req_wdata;
  logic                                   req_ready;
  logic                                   resp_valid;
  logic [DATA_BITWIDTH*BURST_COUNT-1:0]   resp_rdata;
  logic                                   resp_error;
  logic                                   ram_cmd;
  logic                                   ram_cmd_en;
  logic [DEPTH_BITWIDTH-1:0]              ram_addr;
  logic [DATA_BITWIDTH-1:0]               ram_wr_data;
  logic [DATA_BITWIDTH/8-1:0]             ram_data_mask;
  logic [DATA_BITWIDTH-1:0]               ram_rd_data;
  logic                                   ram_rd_data_valid;
  logic                                   ram_busy;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  ram_rd_data, ram_rd_data_valid, ram_busy,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output ram_rd_data, ram_rd_data_valid, ram_busy,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  ram_cmd, ram_cmd_en, ram_addr, ram_wr_data, ram_data_mask
  );
endinterface

// File: rtl/burst_ram_initiator_beat_buffer.sv
// Line buffer of BURST_COUNT beats with a wrapping beat counter; full_o flags the final beat being taken.
module burst_beat_buffer #(
  parameter int DATA_BITWIDTH = 64,
  parameter int BURST_COUNT   = 4,
  parameter int CW            = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load_i,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0] load_line_i,
  input  logic [CW-1:0]                      load_cnt_i,
  input  logic                               wr_en_i,
  input  logic [DATA_BITWIDTH-1:0]           wr_beat_i,
  input  logic                               adv_i,
  output logic [DATA_BITWIDTH-1:0]           beat_o,
  output logic [DATA_BITWIDTH*BURST_COUNT-1:0] line_o,
  output logic                               full_o
);
  logic [DATA_BITWIDTH*BURST_COUNT-1:0] line_q;
  logic [CW-1:0]                        cnt_q;
  logic                                 step;

  assign step   = wr_en_i | adv_i;
  assign full_o = step && (cnt_q == CW'(BURST_COUNT - 1));
  assign beat_o = line_q[int'(cnt_q) * DATA_BITWIDTH +: DATA_BITWIDTH];
  assign line_o = line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      line_q <= load_line_i;
      cnt_q  <= load_cnt_i;
    end else begin
      if (wr_en_i) begin
        line_q[int'(cnt_q) * DATA_BITWIDTH +: DATA_BITWIDTH] <= wr_beat_i;
      end
      if (step) begin
        cnt_q <= full_o ? '0 : cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/burst_ram_initiator.sv
// Whole-line burst RAM initiator: cmd_en one cycle after accept, write beats gap-free, read beats assembled.
// Optional read/drain watchdog under BURST_RAM_INITIATOR_TIMEOUT_EN; req_ready drops until the RAM is idle.
module burst_ram_initiator
  import burst_ram_initiator_pkg::*;
#(
  parameter int DEPTH_BITWIDTH = 4,
  parameter int DATA_BITWIDTH  = 64,
  parameter int BURST_COUNT    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  burst_ram_initiator_if.master bus
);
  localparam int DW = DATA_BITWIDTH;
  localparam int LW = DATA_BITWIDTH * BURST_COUNT;
  localparam int CW = beat_cnt_w(BURST_COUNT);
  localparam logic [DEPTH_BITWIDTH-1:0] LINE_MASK = ~DEPTH_BITWIDTH'(BURST_COUNT - 1);

  state_e                    state_q, state_d;
  logic                      req_ready_q, req_ready_d;
  logic                      resp_valid_q, resp_valid_d;
  logic [LW-1:0]             resp_rdata_q, resp_rdata_d;
  logic                      cmd_q, cmd_d;
  logic                      cmd_en_q, cmd_en_d;
  logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]             wr_data_q, wr_data_d;
  logic                      is_write_q, is_write_d;
  logic [1:0]                guard_q, guard_d;

  logic                      buf_load, buf_wr, buf_adv, buf_full;
  logic [CW-1:0]             buf_load_cnt;
  logic [DW-1:0]             buf_beat;
  logic [LW-1:0]             buf_line;

  // Beat 0 leaves with the command, so a write starts the counter at beat 1.
  assign buf_load_cnt = (bus.req_write && BURST_COUNT > 1) ? CW'(1) : '0;

  burst_beat_buffer #(
    .DATA_BITWIDTH(DATA_BITWIDTH),
    .BURST_COUNT  (BURST_COUNT),
    .CW           (CW)
  ) u_beats (
    .clk        (clk),
    .rst        (rst),
    .load_i     (buf_load),
    .load_line_i(bus.req_wdata),
    .load_cnt_i (buf_load_cnt),
    .wr_en_i    (buf_wr),
    .wr_beat_i  (bus.ram_rd_data),
    .adv_i      (buf_adv),
    .beat_o     (buf_beat),
    .line_o     (buf_line),
    .full_o     (buf_full)
  );

`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          resp_error_q, resp_error_d;
  logic          tmo_hit;

  assign tmo_hit = (state_q == ST_READ_COLLECT || state_q == ST_DRAIN) &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d      = state_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    cmd_d        = cmd_q;
    cmd_en_d     = 1'b0;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    is_write_d   = is_write_q;
    buf_load     = 1'b0;
    buf_wr       = 1'b0;
    buf_adv      = 1'b0;
`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
    resp_error_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_ready_q && bus.req_valid) begin
          is_write_d = bus.req_write;
          cmd_en_d   = 1'b1;
          cmd_d      = bus.req_write ? CMD_WRITE : CMD_READ;
          addr_d     = bus.req_addr & LINE_MASK;
          wr_data_d  = bus.req_wdata[0 +: DW];
          buf_load   = 1'b1;
          if (!bus.req_write)       state_d = ST_READ_COLLECT;
          else if (BURST_COUNT > 1) state_d = ST_WRITE_BEATS;
          else                      state_d = ST_DRAIN;
        end else begin
          req_ready_d = !bus.ram_busy;
        end
      end
      ST_WRITE_BEATS: begin
        wr_data_d = buf_beat;
        buf_adv   = 1'b1;
        if (buf_full) state_d = ST_DRAIN;
      end
      ST_READ_COLLECT: begin
        if (bus.ram_rd_data_valid) begin
          buf_wr = 1'b1;
          if (buf_full) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // ram_busy is not yet meaningful in the cmd_en cycle or the one after.
        if (!bus.ram_busy && guard_q == 2'b00) begin
          resp_valid_d = 1'b1;
          if (!is_write_q) resp_rdata_d = buf_line;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
    if (tmo_hit && !resp_valid_d) begin
      resp_valid_d = 1'b1;
      resp_error_d = 1'b1;
      resp_rdata_d = '0;
      state_d      = ST_IDLE;
    end
`endif
  end

  assign guard_d = {guard_q[0], cmd_en_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      cmd_q        <= CMD_READ;
      cmd_en_q     <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      is_write_q   <= 1'b0;
      guard_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      cmd_q        <= cmd_d;
      cmd_en_q     <= cmd_en_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      is_write_q   <= is_write_d;
      guard_q      <= guard_d;
    end
  end

`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
  always_comb begin
    tmo_d = tmo_q;
    if (state_d != state_q) tmo_d = '0;
    else if (state_q == ST_READ_COLLECT || state_q == ST_DRAIN) tmo_d = tmo_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q        <= '0;
      resp_error_q <= 1'b0;
    end else begin
      tmo_q        <= tmo_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign bus.resp_error = resp_error_q;
`else
  assign bus.resp_error = 1'b0;
`endif

  assign bus.req_ready     = req_ready_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.ram_cmd       = cmd_q;
  assign bus.ram_cmd_en    = cmd_en_q;
  assign bus.ram_addr      = addr_q;
  assign bus.ram_wr_data   = wr_data_q;
  assign bus.ram_data_mask = '0;

endmodule

// File: tb/tb_burst_ram_initiator.sv
// Directed bench for burst_ram_initiator against a latency-8, burst-4 RAM model.
module tb_burst_ram_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  burst_ram_initiator_if #(.DEPTH_BITWIDTH(4), .DATA_BITWIDTH(64), .BURST_COUNT(4)) bus ();

  burst_ram_initiator #(
    .DEPTH_BITWIDTH(4), .DATA_BITWIDTH(64), .BURST_COUNT(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: busy from cmd+1 to last beat+1; write beats at cmd+0..3, read beats at cmd+8..11.
  logic [63:0] mem [16];
  logic        m_active = 1'b0, m_wr = 1'b0, m_busy = 1'b0, m_vld = 1'b0, m_mute = 1'b0, spur = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [63:0] m_data = '0;
  int          m_k = 0;

  assign bus.ram_busy          = m_busy;
  assign bus.ram_rd_data_valid = m_vld | spur;
  assign bus.ram_rd_data       = m_data;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
    forever begin
      @(posedge clk); #1;
      if (m_active) m_k = m_k + 1;
      if (bus.ram_cmd_en) begin
        m_active = 1'b1; m_k = 0; m_wr = bus.ram_cmd; m_addr = bus.ram_addr;
      end
      if (m_active && m_wr && m_k <= 3) mem[(int'(m_addr) + m_k) % 16] = bus.ram_wr_data;
      m_busy = m_active && m_k >= 1 && m_k <= (m_wr ? 4 : 12);
      m_vld  = m_active && !m_wr && !m_mute && m_k >= 8 && m_k <= 11;
      m_data = m_vld ? mem[(int'(m_addr) + m_k - 8) % 16] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (m_active && m_k > 12) m_active = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [3:0] addr, input logic [255:0] line, output int t);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = line;
    while (!bus.req_ready && n < 50) begin tick(); n++; end
    chk("accept_in_budget", 256'(n < 50), 256'd1);
    t = cyc;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic chk_write_beats(input logic [3:0] exp_addr, input logic [255:0] line);
    chk("wr_cmd_en", bus.ram_cmd_en, 1);
    chk("wr_cmd", bus.ram_cmd, 1);
    chk("wr_addr", bus.ram_addr, exp_addr);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wr_beat%0d", k), bus.ram_wr_data, line[k*64 +: 64]);
      if (k == 1) chk("wr_cmd_en_one_cycle", bus.ram_cmd_en, 0);
      tick();
    end
  endtask

  task automatic wait_resp(output int r);
    int n = 0;
    while (!bus.resp_valid && n < 60) begin tick(); n++; end
    chk("resp_in_budget", 256'(n < 60), 256'd1);
    r = cyc;
  endtask

  logic [255:0] la, lb, lc, ld, l0;
  int t, r, t2;

  initial begin
    la = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    lb = {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002, 64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000};
    lc = {64'hC3C3_0000_0000_0003, 64'hC2C2_0000_0000_0002, 64'hC1C1_0000_0000_0001, 64'hC0C0_0000_0000_0000};
    ld = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002, 64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    l0 = {64'hC0DE_0000_0000_0003, 64'hC0DE_0000_0000_0002, 64'hC0DE_0000_0000_0001, 64'hC0DE_0000_0000_0000};
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    // Reset values
    repeat (3) tick();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_error", bus.resp_error, 0);
    chk("rst_ram_cmd", bus.ram_cmd, 0);
    chk("rst_ram_cmd_en", bus.ram_cmd_en, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wr_data", bus.ram_wr_data, 0);
    chk("rst_data_mask", bus.ram_data_mask, 0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", bus.req_ready, 1);

    // Write line A at 4, then read it back at 4 and at unaligned 5
    issue(1'b1, 4'd4, la, t);
    chk_write_beats(4'd4, la);
    wait_resp(r);
    chk("wr_ack_latency", 256'(r - t), 256'd7);
    chk("wr_resp_error", bus.resp_error, 0);
    chk("ready_low_at_resp", bus.req_ready, 0);
    tick();
    chk("ready_after_wr_resp", bus.req_ready, 1);

    issue(1'b0, 4'd4, '0, t);
    chk("rd_cmd_en", bus.ram_cmd_en, 1);
    chk("rd_cmd", bus.ram_cmd, 0);
    chk("rd_addr", bus.ram_addr, 4);
    wait_resp(r);
    chk("rd_ack_latency", 256'(r - t), 256'd15);
    chk("rd_line_a", bus.resp_rdata, la);
    chk("rd_resp_error", bus.resp_error, 0);
    tick();
    chk("ready_after_rd_resp", bus.req_ready, 1);

    issue(1'b0, 4'd5, '0, t);
    chk("rd_unaligned_addr", bus.ram_addr, 4);
    wait_resp(r);
    chk("rd_unaligned_line", bus.resp_rdata, la);
    tick();

    // Back-to-back writes with req_valid held high
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 4'd8; bus.req_wdata = lb;
    t = 0;
    while (!bus.req_ready && t < 50) begin tick(); t++; end
    t = cyc;
    tick();
    bus.req_addr = 4'd12; bus.req_wdata = lc;
    chk_write_beats(4'd8, lb);
    wait_resp(r);
    chk("b2b_first_latency", 256'(r - t), 256'd7);
    chk("b2b_ready_low_at_resp", bus.req_ready, 0);
    tick();
    chk("b2b_second_ready", bus.req_ready, 1);
    t2 = cyc;
    chk("b2b_accept_gap", 256'(t2 - r), 256'd1);
    tick();
    bus.req_valid = 1'b0;
    chk_write_beats(4'd12, lc);
    wait_resp(r);
    chk("b2b_second_latency", 256'(r - t2), 256'd7);
    tick();
    issue(1'b0, 4'd8, '0, t);
    wait_resp(r);
    chk("b2b_read_8", bus.resp_rdata, lb);
    tick();
    issue(1'b0, 4'd12, '0, t);
    wait_resp(r);
    chk("b2b_read_12", bus.resp_rdata, lc);
    tick();

    // Reset during READ_COLLECT after two beats
    issue(1'b0, 4'd0, '0, t);
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_req_ready", bus.req_ready, 0);
    chk("midrst_resp_valid", bus.resp_valid, 0);
    chk("midrst_resp_rdata", bus.resp_rdata, 0);
    chk("midrst_ram_addr", bus.ram_addr, 0);
    chk("midrst_cmd_en", bus.ram_cmd_en, 0);
    tick();
    chk("midrst_ready_busy1", bus.req_ready, 0);
    tick();
    chk("midrst_ready_busy2", bus.req_ready, 0);
    chk("midrst_no_resp", bus.resp_valid, 0);
    tick();
    chk("midrst_ready_idle", bus.req_ready, 1);
    issue(1'b0, 4'd0, '0, t);
    wait_resp(r);
    chk("midrst_read_line", bus.resp_rdata, l0);
    tick();

    // Spurious rd_data_valid while IDLE and during WRITE_BEATS
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("spur_idle_ready%0d", i), bus.req_ready, 1);
      chk($sformatf("spur_idle_resp%0d", i), bus.resp_valid, 0);
    end
    spur = 1'b0;
    chk("spur_idle_rdata", bus.resp_rdata, l0);
    issue(1'b1, 4'd0, ld, t);
    spur = 1'b1;
    chk_write_beats(4'd0, ld);
    spur = 1'b0;
    wait_resp(r);
    chk("spur_wr_latency", 256'(r - t), 256'd7);
    chk("spur_wr_rdata_kept", bus.resp_rdata, l0);
    tick();
    issue(1'b0, 4'd0, '0, t);
    wait_resp(r);
    chk("spur_read_back", bus.resp_rdata, ld);
    tick();

`ifdef BURST_RAM_INITIATOR_TIMEOUT_EN
    // Watchdog: the RAM never returns read beats
    m_mute = 1'b1;
    issue(1'b0, 4'd4, '0, t);
    wait_resp(r);
    chk("tmo_latency", 256'(r - t), 256'd17);
    chk("tmo_error", bus.resp_error, 1);
    chk("tmo_rdata", bus.resp_rdata, 0);
    tick();
    m_mute = 1'b0;
    chk("tmo_pulse_one_cycle", bus.resp_valid, 0);
    chk("tmo_back_to_idle", bus.req_ready, 1);
    issue(1'b0, 4'd4, '0, t);
    wait_resp(r);
    chk("tmo_next_read", bus.resp_rdata, la);
    chk("tmo_next_error", bus.resp_error, 0);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
